// File: rtl/ssd_scan_mux.sv
// ssd_scan_mux: 8-digit time-multiplexed seven-segment scanner with an all-off gap between digits.
// Define SSD_SCAN_LZS_EN to blank the leading zeros of each captured frame.
module ssd_scan_mux #(
   parameter int REFRESH_COUNT = 100000,
   parameter int BLANK_CYCLES  = 1000
) (
   input  logic        ssd_scan_clk,
   input  logic        ssd_scan_rst,
   input  logic [31:0] ssd_scan_data_in,
   input  logic [7:0]  ssd_scan_digit_en,
   input  logic [7:0]  ssd_scan_dp_in,
   output logic [6:0]  ssd_scan_cc,
   output logic        ssd_scan_dp_out,
   output logic [7:0]  ssd_scan_an
);
   localparam int MAXC = REFRESH_COUNT > BLANK_CYCLES ? REFRESH_COUNT : BLANK_CYCLES;
   localparam int CW = $clog2(MAXC);
   // Active-low g..a patterns, digit 0 in the least significant slot
   localparam logic [111:0] SEG = {7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
                                   7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40};
   typedef enum logic {BLANK, SCAN} state_t;
   state_t        state;
   logic [CW-1:0] cnt;
   logic [2:0]    idx;
   logic [31:0]   snap_data;
   logic [7:0]    snap_dp;
   logic [7:0]    snap_en;
   logic [7:0]    keep;
   logic [3:0]    nib;
   logic          last;
   logic          snap;
   logic          lit;
`ifdef SSD_SCAN_LZS_EN
   // Digit i survives only if some nibble at or above it is nonzero; digit 0 always survives
   always_comb begin
      keep = 8'h01;
      for (int i = 1; i < 8; i++) keep[i] = |(ssd_scan_data_in >> (4 * i));
   end
`else
   assign keep = 8'hFF;
`endif
   assign last = cnt == CW'((state == SCAN ? REFRESH_COUNT : BLANK_CYCLES) - 1);
   assign snap = state == BLANK && cnt == '0 && idx == 3'd0;
   assign nib  = snap_data[4 * idx +: 4];
   assign lit  = state == SCAN && snap_en[idx];
   always_ff @(posedge ssd_scan_clk) begin
      if (ssd_scan_rst) begin
         state           <= BLANK;
         cnt             <= '0;
         idx             <= '0;
         snap_data       <= '0;
         snap_dp         <= '0;
         snap_en         <= '0;
         ssd_scan_an     <= 8'hFF;
         ssd_scan_cc     <= 7'h7F;
         ssd_scan_dp_out <= 1'b1;
      end else begin
         cnt <= last ? '0 : cnt + 1'b1;
         if (last) state <= state == SCAN ? BLANK : SCAN;
         if (last && state == SCAN) idx <= idx + 1'b1;
         if (snap) begin
            snap_data <= ssd_scan_data_in;
            snap_dp   <= ssd_scan_dp_in;
            snap_en   <= ssd_scan_digit_en & keep;
         end
         ssd_scan_an     <= lit ? ~(8'b1 << idx) : 8'hFF;
         ssd_scan_cc     <= lit ? SEG[7 * nib +: 7] : 7'h7F;
         ssd_scan_dp_out <= lit ? ~snap_dp[idx] : 1'b1;
      end
   end
endmodule

// File: tb/tb_ssd_scan_mux.sv
// tb_ssd_scan_mux: frame-position reference model feeding a per-cycle scoreboard for ssd_scan_mux.
module tb_ssd_scan_mux;
   localparam int RC = 4;
   localparam int BC = 2;
   localparam int SL = RC + BC;
   localparam int FR = 8 * SL;
   localparam logic [6:0] HEX [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                       7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] data;
   logic [7:0]  en;
   logic [7:0]  dp_in;
   logic [6:0]  cc;
   logic        dp_out;
   logic [7:0]  an;
   int n_cmp = 0;
   int n_err = 0;
   logic [15:0] sbq [$];
   int n;
   logic [31:0] m_data;
   logic [7:0]  m_dp;
   logic [7:0]  m_en;
   logic        found;
   always #5 clk = ~clk;
   ssd_scan_mux #(.REFRESH_COUNT(RC), .BLANK_CYCLES(BC)) dut (
      .ssd_scan_clk(clk), .ssd_scan_rst(rst), .ssd_scan_data_in(data),
      .ssd_scan_digit_en(en), .ssd_scan_dp_in(dp_in), .ssd_scan_cc(cc),
      .ssd_scan_dp_out(dp_out), .ssd_scan_an(an)
   );
   task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
      end
   endtask
   // Model: position in frame decides blank gap vs. digit slot; frame data captured at frame start
   always @(posedge clk) begin : model
      int p;
      int s;
      int h;
      logic [15:0] e;
      e = 16'hFFFF;
      if (rst) begin
         n = 0;
         m_data = '0;
         m_dp = '0;
         m_en = '0;
      end else begin
         if (n % FR == 0) begin
            m_data = data;
            m_dp = dp_in;
            m_en = en;
`ifdef SSD_SCAN_LZS_EN
            h = 0;
            for (int i = 0; i < 8; i++) if (m_data[4 * i +: 4] != 4'h0) h = i;
            for (int i = 0; i < 8; i++) if (i > h) m_en[i] = 1'b0;
`endif
         end
         p = n % FR;
         n++;
         s = p / SL;
         if (p % SL >= BC && m_en[s]) e = {~(8'b1 << s), HEX[m_data[4 * s +: 4]], ~m_dp[s]};
      end
      sbq.push_back(e);
   end
   always @(negedge clk) if (sbq.size() > 0) check("scan", {an, cc, dp_out}, sbq.pop_front());
   initial begin
      data = 32'h76543210;
      en = 8'hFF;
      dp_in = 8'h00;
      rst = 1'b1;
      found = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      repeat (FR + 20) @(negedge clk);
      data = 32'hFFFFFFFF;
      repeat (2 * FR - 20) @(negedge clk);
      data = 32'h76543210;
      en = 8'b0000_0101;
      dp_in = 8'h04;
      repeat (2 * FR) @(negedge clk);
      en = 8'hFF;
      dp_in = 8'hA5;
      for (int i = 0; i < 200 && !found; i++) begin
         @(negedge clk);
         found = an == 8'hDF;
      end
      check("wait_digit5", {15'd0, found}, 16'd1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      repeat (FR + 10) @(negedge clk);
      data = 32'h00000A00;
      repeat (FR) @(negedge clk);
      data = 32'h0;
      repeat (FR) @(negedge clk);
      data = 32'h00F00001;
      repeat (FR) @(negedge clk);
      repeat (600) begin
         @(negedge clk);
         if ($urandom_range(0, 9) == 0) begin
            data = $urandom >> (4 * $urandom_range(0, 7));
            en = 8'($urandom);
            dp_in = 8'($urandom);
         end
         rst = $urandom_range(0, 149) == 0;
      end
      rst = 1'b0;
      repeat (3) @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
